// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the RV32 ALU control unit: operation codes, ALU_Op
// classes, funct7 patterns and the multi-cycle sequencer states.
package alu_ctrl_pkg;

  typedef enum logic [4:0] {
    OP_ADD    = 5'd0,
    OP_SUB    = 5'd1,
    OP_SLL    = 5'd2,
    OP_SLT    = 5'd3,
    OP_SLTU   = 5'd4,
    OP_XOR    = 5'd5,
    OP_SRL    = 5'd6,
    OP_SRA    = 5'd7,
    OP_OR     = 5'd8,
    OP_AND    = 5'd9,
    OP_PASS_B = 5'd10,
    OP_MUL    = 5'd16,
    OP_MULH   = 5'd17,
    OP_MULHSU = 5'd18,
    OP_MULHU  = 5'd19,
    OP_DIV    = 5'd20,
    OP_DIVU   = 5'd21,
    OP_REM    = 5'd22,
    OP_REMU   = 5'd23
  } alu_op_e;

  localparam logic [2:0] CLS_R     = 3'b000;
  localparam logic [2:0] CLS_I     = 3'b001;
  localparam logic [2:0] CLS_LUI   = 3'b010;
  localparam logic [2:0] CLS_BR    = 3'b011;
  localparam logic [2:0] CLS_MEM   = 3'b100;
  localparam logic [2:0] CLS_AUIPC = 3'b101;
  localparam logic [2:0] CLS_JUMP  = 3'b110;
  localparam logic [2:0] CLS_RSVD  = 3'b111;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } mc_state_e;

  // funct3 ordering shared by R-type base ops and the non-shift I-type ops.
  function automatic alu_op_e base_op(input logic [2:0] funct3);
    alu_op_e op;
    case (funct3)
      3'b000:  op = OP_ADD;
      3'b001:  op = OP_SLL;
      3'b010:  op = OP_SLT;
      3'b011:  op = OP_SLTU;
      3'b100:  op = OP_XOR;
      3'b101:  op = OP_SRL;
      3'b110:  op = OP_OR;
      default: op = OP_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_op_decoder.sv
// Pure combinational decode of ALU_Op / funct3 / funct7 into an operation
// code, an illegal flag and multi-cycle / divide qualifiers.
module alu_op_decoder
  import alu_ctrl_pkg::*;
#(
  parameter bit ENABLE_M = 1'b1
) (
  input  logic [2:0] alu_op_i,
  input  logic [2:0] funct3_i,
  input  logic [6:0] funct7_i,
  output alu_op_e    op_o,
  output logic       illegal_o,
  output logic       is_multicycle_o,
  output logic       is_div_o
);

  alu_op_e op_raw;
  logic    illegal_raw;

  // NOTE: every output of an always_comb gets a default first; a path that
  // leaves one unassigned would infer a latch.
  always_comb begin
    op_raw      = OP_ADD;
    illegal_raw = 1'b0;
    case (alu_op_i)
      CLS_R: begin
        if (funct7_i == F7_BASE) begin
          op_raw = base_op(funct3_i);
        end else if (funct7_i == F7_ALT) begin
          if (funct3_i == 3'b000)      op_raw = OP_SUB;
          else if (funct3_i == 3'b101) op_raw = OP_SRA;
          else                         illegal_raw = 1'b1;
        end else if (ENABLE_M && funct7_i == F7_MULDIV) begin
          op_raw = alu_op_e'({2'b10, funct3_i});
        end else begin
          illegal_raw = 1'b1;
        end
      end
      CLS_I: begin
        if (funct3_i == 3'b001) begin
          if (funct7_i == F7_BASE) op_raw = OP_SLL;
          else                     illegal_raw = 1'b1;
        end else if (funct3_i == 3'b101) begin
          if (funct7_i == F7_BASE)     op_raw = OP_SRL;
          else if (funct7_i == F7_ALT) op_raw = OP_SRA;
          else                         illegal_raw = 1'b1;
        end else begin
          op_raw = base_op(funct3_i);
        end
      end
      CLS_LUI: op_raw = OP_PASS_B;
      CLS_BR: begin
        case (funct3_i[2:1])
          2'b00:   op_raw = OP_SUB;
          2'b10:   op_raw = OP_SLT;
          2'b11:   op_raw = OP_SLTU;
          default: illegal_raw = 1'b1;
        endcase
      end
      CLS_MEM, CLS_AUIPC, CLS_JUMP: op_raw = OP_ADD;
      CLS_RSVD: illegal_raw = 1'b1;
      default:  illegal_raw = 1'b1;
    endcase
  end

  assign op_o            = illegal_raw ? OP_ADD : op_raw;
  assign illegal_o       = illegal_raw;
  assign is_multicycle_o = !illegal_raw && op_raw[4];
  assign is_div_o        = !illegal_raw && op_raw[4] && op_raw[2];

endmodule

// File: rtl/alu_control_mc.sv
// ALU control unit top: combinational decode for single-cycle ops plus a
// start/busy/done sequencer that stalls the PC during MUL/DIV/REM.
module alu_control_mc
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned OP_W       = 5,
  parameter bit          ENABLE_M   = 1'b1,
  parameter int unsigned MUL_CYCLES = 3,
  parameter int unsigned DIV_CYCLES = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            valid_i,
  input  logic [2:0]      alu_op_i,
  input  logic [2:0]      funct3_i,
  input  logic [6:0]      funct7_i,
  input  logic            flush_i,
  output logic [OP_W-1:0] alu_operation_o,
  output logic            illegal_o,
  output logic            start_o,
  output logic            stall_o,
  output logic            busy_o,
  output logic            done_o
);

  localparam int unsigned MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES);
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 2);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 2);

  alu_op_e    dec_op;
  logic       dec_illegal;
  logic       dec_multi;
  logic       dec_div;

  mc_state_e  state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  alu_op_e    op_q, op_d;

  alu_op_e    op_out;
  logic       illegal_out, start_out, stall_out, busy_out, done_out;

  alu_op_decoder #(
    .ENABLE_M (ENABLE_M)
  ) u_decoder (
    .alu_op_i        (alu_op_i),
    .funct3_i        (funct3_i),
    .funct7_i        (funct7_i),
    .op_o            (dec_op),
    .illegal_o       (dec_illegal),
    .is_multicycle_o (dec_multi),
    .is_div_o        (dec_div)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of the others.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= OP_ADD;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    op_out      = OP_ADD;
    illegal_out = 1'b0;
    start_out   = 1'b0;
    stall_out   = 1'b0;
    busy_out    = 1'b0;
    done_out    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (valid_i) begin
          illegal_out = dec_illegal;
          op_out      = dec_op;
        end
        if (valid_i && dec_multi && !flush_i) begin
          start_out = 1'b1;
          stall_out = 1'b1;
          op_d      = dec_op;
          cnt_d     = dec_div ? DIV_LOAD : MUL_LOAD;
          state_d   = S_BUSY;
        end
      end
      S_BUSY: begin
        op_out    = op_q;
        stall_out = 1'b1;
        busy_out  = 1'b1;
        if (cnt_q == '0) state_d = S_DONE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      S_DONE: begin
        // Always drop back to IDLE so the instruction still on the inputs
        // is not launched a second time.
        op_out   = op_q;
        busy_out = 1'b1;
        done_out = !flush_i;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (flush_i) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end
  end

  // Reset is asynchronous at the outputs too: everything reads zero while it is high.
  assign alu_operation_o = reset ? '0 : OP_W'(op_out);
  assign illegal_o       = !reset && illegal_out;
  assign start_o         = !reset && start_out;
  assign stall_o         = !reset && stall_out;
  assign busy_o          = !reset && busy_out;
  assign done_o          = !reset && done_out;

endmodule
